mem_arbiter_2m: RTL and testbench

- Two-master arbiter for the picorv32 native memory interface (valid/ready/addr/wdata/wstrb/rdata).
- Lets the core (m0) and a second requester (m1, e.g. a loader/DMA or signature-dump engine) share one memory port.
- Round-robin grant; request fields latched at grant; one outstanding transaction at a time.
- Optional watchdog completes hung transactions.

---
 rtl/mem_arbiter_2m.sv | 136 +++++++++++++
 tb/tb_mem_arbiter_2m.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2m.sv
// Two-master round-robin arbiter for the picorv32 native memory interface.
// Optional watchdog (macro MEM_ARBITER_TIMEOUT_EN) force-completes hung transactions.
module mem_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_arbiter_2m: TIMEOUT_CYCLES must be >= 2");
    end

    state_t         state, state_n;
    logic           prio, prio_n;
    logic           grant, grant_n;
    logic           valid_q, valid_n;
    mem_req_t       req_q, req_n;
    mem_req_t [1:0] m_req;
    logic           win_any, win;
    logic           done, to_hit;

    assign m_req[0] = {m0_instr, m0_addr, m0_wdata, m0_wstrb};
    assign m_req[1] = {m1_instr, m1_addr, m1_wdata, m1_wstrb};

    // Single requester wins outright; a tie goes to the master indexed by prio.
    assign win_any = m0_valid | m1_valid;
    assign win     = (m0_valid & m1_valid) ? prio : m1_valid;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    // A real mem_ready in the threshold cycle takes precedence over the timeout.
    assign to_hit      = (state == BUSY) && !mem_ready && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = to_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wd_cnt <= '0;
        else if (state == IDLE)
            wd_cnt <= '0;
        else if (!mem_ready)
            wd_cnt <= wd_cnt + CW'(1);
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign done     = (state == BUSY) && (mem_ready || to_hit);
    assign m0_ready = done && !grant;
    assign m1_ready = done && grant;
    assign m0_rdata = to_hit ? TIMEOUT_RDATA : mem_rdata;
    assign m1_rdata = to_hit ? TIMEOUT_RDATA : mem_rdata;

    always_comb begin
        state_n = state;
        prio_n  = prio;
        grant_n = grant;
        valid_n = valid_q;
        req_n   = req_q;
        case (state)
            IDLE: begin
                if (win_any) begin
                    grant_n = win;
                    req_n   = m_req[win];
                    valid_n = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    valid_n = 1'b0;
                    prio_n  = ~grant;
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            prio    <= 1'b0;
            grant   <= 1'b0;
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            state   <= state_n;
            prio    <= prio_n;
            grant   <= grant_n;
            valid_q <= valid_n;
            req_q   <= req_n;
        end
    end

    assign mem_valid = valid_q;
    assign mem_instr = req_q.instr;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_mem_arbiter_2m.sv
// Scoreboard bench for mem_arbiter_2m: expected (master, rdata) entries are queued
// in grant order and popped on every master ready pulse.
module tb_mem_arbiter_2m;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        timeout_err;

    always #5 clk = ~clk;

    mem_arbiter_2m #(.TIMEOUT_CYCLES(4), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: configurable wait states, hang switch, spurious-ready injector.
    logic [31:0] tbmem [0:1023];
    int wcnt = 0;
    int wait_states = 0;
    bit hang = 0;
    bit spur = 0;

    assign mem_ready = spur | (mem_valid & ~hang & (wcnt >= wait_states));
    assign mem_rdata = tbmem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_valid && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (mem_valid && mem_ready)
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) tbmem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'h5A00_0000 + {22'd0, a[11:2]};
    endfunction

    typedef struct {
        int          id;
        bit          rd;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    task automatic expect_txn(input int id, input bit rd, input logic [31:0] d);
        exp_t e;
        e.id = id; e.rd = rd; e.rdata = d;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (resetn && (m0_ready || m1_ready)) begin
            exp_t e;
            check("ready_excl", {31'd0, m0_ready & m1_ready}, 32'd0);
            if (sbq.size() == 0) begin
                check("stray_ready", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("grant_id", {31'd0, m1_ready}, e.id);
                if (e.rd) check("rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    end

    // Caller is just after a rising edge; valid drops one edge after the ready pulse.
    task automatic drive(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        bit got = 0;
        if (id == 0) begin
            m0_instr = 0; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1;
        end else begin
            m1_instr = 0; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? m0_ready : m1_ready;
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (id == 0) m0_valid = 0; else m1_valid = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        m0_valid = 0; m1_valid = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_watchdog got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) tbmem[i] = pat(i << 2);
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_readies", {30'd0, m0_ready, m1_ready}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        resetn = 1;

        // 1: single m0 instruction read, zero-wait memory
        tbmem[32'h100 >> 2] = 32'h1234_5678;
        expect_txn(0, 1, 32'h1234_5678);
        @(posedge clk); #1;
        m0_instr = 1; m0_addr = 32'h100; m0_wdata = 0; m0_wstrb = 0; m0_valid = 1;
        @(negedge clk);
        check("t1_valid_n", {31'd0, mem_valid}, 32'd0);
        check("t1_ready_n", {31'd0, m0_ready}, 32'd0);
        @(negedge clk);
        check("t1_valid_n1", {31'd0, mem_valid}, 32'd1);
        check("t1_addr", mem_addr, 32'h100);
        check("t1_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("t1_instr", {31'd0, mem_instr}, 32'd1);
        check("t1_m0_ready", {31'd0, m0_ready}, 32'd1);
        check("t1_m1_ready", {31'd0, m1_ready}, 32'd0);
        @(posedge clk); #1;
        m0_valid = 0; m0_instr = 0;
        @(negedge clk);
        check("t1_valid_drop", {31'd0, mem_valid}, 32'd0);

        // 2: both valid from reset, m0 write then m1 read
        do_reset();
        expect_txn(0, 0, 32'd0);
        expect_txn(1, 1, pat(32'h300));
        @(posedge clk); #1;
        fork
            drive(0, 32'h200, 32'hCAFE_BABE, 4'hF);
            drive(1, 32'h300, 32'd0, 4'h0);
        join
        check("t2_write", tbmem[32'h200 >> 2], 32'hCAFE_BABE);

        // 3: continuous contention alternates strictly
        for (int i = 0; i < 4; i++) begin
            expect_txn(0, 1, pat(32'h400 + i * 4));
            expect_txn(1, 1, pat(32'h500 + i * 4));
        end
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 4; i++) drive(0, 32'h400 + i * 4, 32'd0, 4'h0);
            for (int j = 0; j < 4; j++) drive(1, 32'h500 + j * 4, 32'd0, 4'h0);
        join

        // 4: m1 read with 3 wait states, addr changed while waiting
        wait_states = 3;
        expect_txn(1, 1, pat(32'h600));
        @(posedge clk); #1;
        m1_addr = 32'h600; m1_wstrb = 0; m1_valid = 1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_valid) begin
                check("t4_addr_hold", mem_addr, 32'h600);
                m1_addr = 32'h700;
            end
            if (m1_ready) begin
                n++;
                check("t4_ready_cycle", c, 32'd4);
                m1_valid = 0;
            end
        end
        check("t4_single_pulse", n, 32'd1);
        wait_states = 0;

        // master drops valid while granted: transaction still completes
        wait_states = 2;
        expect_txn(0, 1, pat(32'h640));
        @(posedge clk); #1;
        m0_addr = 32'h640; m0_wstrb = 0; m0_valid = 1;
        @(posedge clk); #1;
        m0_valid = 0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (m0_ready) n++;
        end
        check("drop_valid_ready", n, 32'd1);
        wait_states = 0;

        // mem_ready while IDLE is ignored
        @(posedge clk); #1;
        spur = 1;
        @(negedge clk);
        check("idle_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
        @(posedge clk); #1;
        spur = 0;
        @(negedge clk);
        check("idle_after_spur", {31'd0, mem_valid}, 32'd0);

        // 5: reset during BUSY abandons the transaction
        hang = 1;
        @(posedge clk); #1;
        m1_addr = 32'h680; m1_wstrb = 0; m1_valid = 1;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy", {31'd0, mem_valid}, 32'd1);
        #2 resetn = 0;
        #1;
        check("t5_valid_async", {31'd0, mem_valid}, 32'd0);
        check("t5_no_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
        m1_valid = 0;
        hang = 0;
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        check("t5_idle", {31'd0, mem_valid}, 32'd0);
        expect_txn(0, 1, pat(32'h6C0));
        expect_txn(1, 1, pat(32'h6C4));
        @(posedge clk); #1;
        fork
            drive(0, 32'h6C0, 32'd0, 4'h0);
            drive(1, 32'h6C4, 32'd0, 4'h0);
        join

`ifdef MEM_ARBITER_TIMEOUT_EN
        // 6: watchdog forces completion in the 4th BUSY cycle
        hang = 1;
        expect_txn(0, 1, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        m0_addr = 32'h100; m0_wstrb = 0; m0_valid = 1;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t6_valid", {31'd0, mem_valid}, 32'd1);
            check("t6_ready", {31'd0, m0_ready}, (k == 4) ? 32'd1 : 32'd0);
            check("t6_err", {31'd0, timeout_err}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) check("t6_rdata", m0_rdata, 32'hDEAD_BEEF);
        end
        @(posedge clk); #1;
        m0_valid = 0;
        hang = 0;
        @(negedge clk);
        check("t6_err_clear", {31'd0, timeout_err}, 32'd0);
        expect_txn(1, 1, pat(32'h300));
        @(posedge clk); #1;
        drive(1, 32'h300, 32'd0, 4'h0);
`else
        check("no_wd_err", {31'd0, timeout_err}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
